mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequential arbiter sharing the single unified instruction/data memory port between the multicycle CPU and a DMA/loader requester. Each requester issues one transaction at a time over a req/ack handshake. The arbiter picks an owner, drives the memory for a parameterised number of wait cycles, captures read data and returns a one-cycle acknowledge. It sits between the CPU's memory-access path (IorD-selected address, memread/memwrite) and the memory model.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `WAIT`, 1, extra memory-access cycles (0..15)

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU transaction request; held until `cpu_ack`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  AW  CPU address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_rdata`  out  DW  registered read data for the CPU
- `cpu_ack`  out  1  one-cycle completion pulse to the CPU
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_ack`: same widths and meanings as the CPU ports, for the DMA requester
- `mem_en`  out  1  memory access active
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, combinational from `mem_addr`

## Operation
- FSM states are IDLE, BUSY and DONE. Owner register `own` is 0 for CPU and 1 for DMA. Other registers are `last`, `cnt[3:0]`, and latched `we`/`addr`/`wdata`.
- **IDLE**
  - If any req is high, select the owner (see Configuration).
  - Latch the owner's we/addr/wdata and load `cnt=WAIT`.
  - Go to BUSY and set `last=own`.
- **BUSY**
  - `mem_en=1`, `mem_we=we`; `mem_addr` and `mem_wdata` come from the latched registers.
  - If `cnt!=0`, decrement and stay.
  - If `cnt==0` and it is a read, capture `mem_rdata` into the owner's rdata register. Go to DONE.
- **DONE**
  - The owner's ack is 1 for exactly this cycle. Go to IDLE.
  - No arbitration takes place in DONE.
- **Handshake rules**
  - The requester holds req, we, addr and wdata stable from assertion until ack.
  - The requester deasserts req on the edge that ends the ack cycle.
  - Inputs that change during BUSY are ignored, because the latched values are used.
  - A req still high in IDLE after DONE is treated as a new transaction.
- **Register holding and idle outputs**
  - The non-owner's rdata and ack never change during another owner's transaction.
  - A write leaves the owner's rdata unchanged.
  - In IDLE and DONE, `mem_en=0` and `mem_we=0`; `mem_addr` and `mem_wdata` hold their last latched values.
- **Reset** (`rst` low, asynchronous, including mid-BUSY)
  - State goes to IDLE.
  - `mem_en`, `mem_we`, both acks, both rdata, `mem_addr`, `mem_wdata` and `cnt` go to 0.
  - `last` goes to 1, so the CPU wins the first tie.
  - An in-flight transaction is dropped with no ack.

## Timing
- Request high in cycle 0 and IDLE: BUSY for cycles 1..WAIT+1, giving WAIT+1 cycles of `mem_en`. Ack in cycle WAIT+2.
- Total latency from req to ack is WAIT+2 cycles. Minimum spacing between grants is WAIT+3 cycles.
- Write commits at every BUSY edge with identical data, so it is idempotent. Memory content is final after the last BUSY edge.
- Read data is valid in the rdata register from the ack cycle onward and holds until the next read by the same requester.

## Configuration
- `MEM_ARB_RR_EN`, defined: round-robin arbitration.
  - When both reqs are high in IDLE, grant the one that is not `last`.
  - With both reqs held continuously, grants alternate CPU, DMA, CPU, ...
- `MEM_ARB_RR_EN`, undefined: fixed priority, CPU always wins ties.
  - `last` is still maintained but unused.
  - A continuously requesting CPU starves the DMA.

## Test plan
1. Assert `rst`=0 mid-run, then check outputs: all outputs 0 immediately (asynchronously), state IDLE. After release, a CPU read completes normally.
2. `WAIT=2`, memory holds 0x12345678 at 0x40, CPU read of 0x40 asserted at cycle 0:
   - `mem_en` high in cycles 1–3;
   - `cpu_ack` high only in cycle 4 with `cpu_rdata`=0x12345678;
   - `dma_rdata` stays 0.
3. DMA writes 0xDEADBEEF to 0x100, then CPU reads 0x100 → `cpu_rdata`=0xDEADBEEF. `mem_we` is high only during the DMA BUSY cycles.
4. `MEM_ARB_RR_EN` defined, both reqs held for four transactions → ack order CPU, DMA, CPU, DMA. Undefined → CPU ×4, no `dma_ack`.
5. `rst` low in the second BUSY cycle of a DMA write → no `dma_ack`. After release, the CPU read of the same address returns the new or old data without hang, and its ack arrives WAIT+2 cycles after req.
6. `WAIT=0`, CPU `cpu_addr` changed during BUSY → `mem_addr` keeps the latched value, latency is 2 cycles, ack lasts exactly one cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between the multicycle CPU and a DMA/loader requester.
// Tie-breaking is fixed CPU priority unless MEM_ARB_RR_EN is defined (round-robin).

module mem_port_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic mem_en,
  input logic mem_we,
  input logic cpu_ack,
  input logic dma_ack,
  input logic own,
  input logic last
);

  a_single_ack: assert property (@(posedge clk) disable iff (!rst) !(cpu_ack && dma_ack));

  a_we_needs_en: assert property (@(posedge clk) disable iff (!rst) mem_we |-> mem_en);

  a_cpu_ack_pulse: assert property (@(posedge clk) disable iff (!rst) cpu_ack |=> !cpu_ack);

  a_dma_ack_pulse: assert property (@(posedge clk) disable iff (!rst) dma_ack |=> !dma_ack);

  // While the port is driven, the round-robin history must name the current owner
  a_last_tracks_owner: assert property (@(posedge clk) disable iff (!rst) mem_en |-> (last == own));

endmodule

module mem_port_arbiter #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t        state_r;
  logic          own_r;
  logic          last_r;
  logic [3:0]    cnt_r;
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic          mem_en_r;
  logic          mem_we_r;
  logic          cpu_ack_r;
  logic          dma_ack_r;
  logic [DW-1:0] cpu_rdata_r;
  logic [DW-1:0] dma_rdata_r;

  logic          any_req_s;
  logic          grant_s;
  logic          req_we_s;
  logic [AW-1:0] req_addr_s;
  logic [DW-1:0] req_wdata_s;

  assign any_req_s = cpu_req | dma_req;

  // Owner chosen for a grant taken in IDLE (0 = CPU, 1 = DMA)
  always_comb begin
    grant_s = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (cpu_req && dma_req) begin
      grant_s = ~last_r;
    end else if (dma_req) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
`else
    if (cpu_req) begin
      grant_s = 1'b0;
    end else if (dma_req) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
`endif
  end

  // Transaction fields of the selected requester
  always_comb begin
    req_we_s    = cpu_we;
    req_addr_s  = cpu_addr;
    req_wdata_s = cpu_wdata;
    if (grant_s) begin
      req_we_s    = dma_we;
      req_addr_s  = dma_addr;
      req_wdata_s = dma_wdata;
    end else begin
      req_we_s    = cpu_we;
      req_addr_s  = cpu_addr;
      req_wdata_s = cpu_wdata;
    end
  end

  // Arbitration FSM; every output comes straight from a register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      own_r       <= 1'b0;
      last_r      <= 1'b1;
      cnt_r       <= 4'd0;
      we_r        <= 1'b0;
      addr_r      <= {AW{1'b0}};
      wdata_r     <= {DW{1'b0}};
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      cpu_ack_r   <= 1'b0;
      dma_ack_r   <= 1'b0;
      cpu_rdata_r <= {DW{1'b0}};
      dma_rdata_r <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          cpu_ack_r <= 1'b0;
          dma_ack_r <= 1'b0;
          if (any_req_s) begin
            own_r    <= grant_s;
            last_r   <= grant_s;
            we_r     <= req_we_s;
            addr_r   <= req_addr_s;
            wdata_r  <= req_wdata_s;
            cnt_r    <= WAIT_CNT;
            mem_en_r <= 1'b1;
            mem_we_r <= req_we_s;
            state_r  <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            // Last access cycle: memory read data is stable on the latched address
            if (!we_r) begin
              if (own_r) begin
                dma_rdata_r <= mem_rdata;
              end else begin
                cpu_rdata_r <= mem_rdata;
              end
            end
            cpu_ack_r <= ~own_r;
            dma_ack_r <= own_r;
            mem_en_r  <= 1'b0;
            mem_we_r  <= 1'b0;
            state_r   <= DONE;
          end
        end
        DONE: begin
          cpu_ack_r <= 1'b0;
          dma_ack_r <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          cpu_ack_r <= 1'b0;
          dma_ack_r <= 1'b0;
          mem_en_r  <= 1'b0;
          mem_we_r  <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_r;
  assign cpu_ack   = cpu_ack_r;
  assign dma_rdata = dma_rdata_r;
  assign dma_ack   = dma_ack_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

  mem_port_arbiter_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .mem_en  (mem_en_r),
    .mem_we  (mem_we_r),
    .cpu_ack (cpu_ack_r),
    .dma_ack (dma_ack_r),
    .own     (own_r),
    .last    (last_r)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level timing model.
// Honours MEM_ARB_RR_EN the same way the design does.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int W = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dma_addr, dma_wdata, dma_rdata;
  logic        cpu_ack, dma_ack, mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // Memory model: unwritten words return a fixed pattern
  logic [31:0] tb_mem [256];
  bit          wr_v   [256];

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 16) return 32'h1234_5678;
    return 32'h5A5A_0000 ^ (32'(idx) * 32'h0000_0101);
  endfunction

  assign mem_rdata = wr_v[mem_addr[9:2]] ? tb_mem[mem_addr[9:2]] : init_word(int'(mem_addr[9:2]));

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      tb_mem[mem_addr[9:2]] <= mem_wdata;
      wr_v[mem_addr[9:2]]   <= 1'b1;
    end
  end

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .WAIT(W)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: current transaction granted at cycle g
  bit          act = 1'b0;
  int          g   = 0;
  bit          m_own, m_we;
  bit          m_last = 1'b1;
  logic [31:0] m_addr, m_wdata, m_rd, m_old;
  logic [31:0] e_addr = 32'd0, e_wdata = 32'd0, e_cpu_rd = 32'd0, e_dma_rd = 32'd0;
  logic [31:0] ref_mem [256];

  // Requester agents (0 = CPU, 1 = DMA)
  bit          pend  [2];
  logic        p_we  [2];
  logic [31:0] p_addr[2];
  logic [31:0] p_wdata[2];
  int          rate  [2];
  txn_t        scr_cpu[$];
  txn_t        scr_dma[$];
  bit          rst_busy2 = 1'b0;
  int          rst_pm = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    bit en, ca, da;
    en = act && (cyc >= g + 1) && (cyc <= g + W + 1);
    ca = act && (cyc == g + W + 2) && !m_own;
    da = act && (cyc == g + W + 2) && m_own;
    check_val("mem_en",    32'(mem_en),  32'(en));
    check_val("mem_we",    32'(mem_we),  32'(en && m_we));
    check_val("mem_addr",  mem_addr,     e_addr);
    check_val("mem_wdata", mem_wdata,    e_wdata);
    check_val("cpu_ack",   32'(cpu_ack), 32'(ca));
    check_val("dma_ack",   32'(dma_ack), 32'(da));
    check_val("cpu_rdata", cpu_rdata,    e_cpu_rd);
    check_val("dma_rdata", dma_rdata,    e_dma_rd);
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b0;
    #1;
    // Before the first BUSY edge no write has reached memory yet
    if (act && m_we && cyc == g + 1) ref_mem[m_addr[9:2]] = m_old;
    act = 1'b0; m_last = 1'b1;
    e_addr = 32'd0; e_wdata = 32'd0; e_cpu_rd = 32'd0; e_dma_rd = 32'd0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    cpu_req = 1'b0; dma_req = 1'b0;
    check_all();
    repeat (hold) begin
      @(negedge clk);
      cyc++;
      check_all();
    end
    rst = 1'b1;
  endtask

  task automatic new_txn(input int i);
    txn_t       t;
    logic [7:0] idx;
    if (i == 0 && scr_cpu.size() > 0) begin
      t = scr_cpu.pop_front();
    end else if (i == 1 && scr_dma.size() > 0) begin
      t = scr_dma.pop_front();
    end else if ($urandom_range(99) < rate[i]) begin
      idx     = 8'($urandom_range(255));
      t.we    = 1'($urandom);
      t.addr  = {22'd0, idx, 2'b00};
      t.wdata = $urandom;
    end else begin
      return;
    end
    pend[i] = 1'b1; p_we[i] = t.we; p_addr[i] = t.addr; p_wdata[i] = t.wdata;
  endtask

  task automatic step();
    bit in_busy, o;
    if (rst_busy2 && act && m_own && m_we && cyc == g + 2) begin
      rst_busy2 = 1'b0;
      do_reset(2);
    end else if (rst_pm != 0 && $urandom_range(999) < rst_pm) begin
      do_reset($urandom_range(1, 3));
    end
    if (act && cyc == g + 1) begin e_addr = m_addr; e_wdata = m_wdata; end
    if (act && cyc == g + W + 2 && !m_we) begin
      if (m_own) e_dma_rd = m_rd; else e_cpu_rd = m_rd;
    end
    if (act && cyc == g + W + 3) act = 1'b0;
    check_all();
    if (act && cyc == g + W + 2) pend[m_own] = 1'b0;
    for (int i = 0; i < 2; i++) if (!pend[i]) new_txn(i);
    // The owner may scribble on its inputs while the port is busy
    in_busy = act && (cyc >= g + 1) && (cyc <= g + W + 1);
    cpu_req = pend[0];
    dma_req = pend[1];
    if (pend[0] && !(in_busy && !m_own)) begin
      cpu_we = p_we[0]; cpu_addr = p_addr[0]; cpu_wdata = p_wdata[0];
    end else begin
      cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
    end
    if (pend[1] && !(in_busy && m_own)) begin
      dma_we = p_we[1]; dma_addr = p_addr[1]; dma_wdata = p_wdata[1];
    end else begin
      dma_we = 1'($urandom); dma_addr = $urandom; dma_wdata = $urandom;
    end
    if (!act && (pend[0] || pend[1])) begin
`ifdef MEM_ARB_RR_EN
      o = (pend[0] && pend[1]) ? !m_last : pend[1];
`else
      o = !pend[0];
`endif
      act = 1'b1; g = cyc; m_own = o; m_last = o;
      m_we = p_we[o]; m_addr = p_addr[o]; m_wdata = p_wdata[o];
      m_old = ref_mem[m_addr[9:2]];
      if (m_we) ref_mem[m_addr[9:2]] = m_wdata;
      else m_rd = ref_mem[m_addr[9:2]];
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    pend[0] = 1'b0; pend[1] = 1'b0;
    rate[0] = 0; rate[1] = 0;
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b1;

    // CPU read of the preloaded word
    scr_cpu.push_back('{1'b0, 32'h0000_0040, 32'h0});
    run(10);
    // DMA write then CPU read-back
    scr_dma.push_back('{1'b1, 32'h0000_0100, 32'hDEAD_BEEF});
    run(8);
    scr_cpu.push_back('{1'b0, 32'h0000_0100, 32'h0});
    run(8);
    // Both requesters held for back-to-back transactions
    for (int k = 0; k < 4; k++) begin
      scr_cpu.push_back('{1'b0, 32'(k * 4), 32'h0});
      scr_dma.push_back('{1'b1, 32'h200 + 32'(k * 4), 32'hA000_0000 + 32'(k)});
    end
    run(50);
    // Reset in the second BUSY cycle of a DMA write, then read the same word
    scr_dma.push_back('{1'b1, 32'h0000_0080, 32'hCAFE_F00D});
    rst_busy2 = 1'b1;
    run(6);
    scr_cpu.push_back('{1'b0, 32'h0000_0080, 32'h0});
    run(10);
    // Random traffic with occasional mid-run resets
    rate[0] = 40; rate[1] = 30; rst_pm = 3;
    run(3000);
    rate[0] = 0; rate[1] = 0; rst_pm = 0;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
